// File: rtl/mean_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : mean_engine_if
// Description : Control, sample and result bundle for mean_engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface mean_engine_if #(
    parameter int DATA_W = 8,
    parameter int N      = 8
);
    localparam int CNT_W = $clog2(N + 1);
    localparam int ACC_W = DATA_W + CNT_W;

    logic              start;
    logic              clear;
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] mean;
    logic [CNT_W-1:0]  rem;
    logic              zOz;

    modport master (
        output start, clear, mode, in_valid, in_data,
        input  in_ready, busy, done, sum, mean, rem, zOz
    );

    modport slave (
        input  start, clear, mode, in_valid, in_data,
        output in_ready, busy, done, sum, mean, rem, zOz
    );
endinterface
`default_nettype wire

// File: rtl/mean_engine.sv
`default_nettype none
// ============================================================================
// Module      : mean_engine
// Description : Accumulates N unsigned samples, then reports the sum and a
//               restoring-division mean/remainder (or the sum alone).
// Revision    : 1.0 - initial release
// ============================================================================
module mean_engine #(
    parameter int DATA_W = 8,
    parameter int N      = 8
) (
    input  logic          clk,
    input  logic          rst,
    mean_engine_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam int ACC_W = DATA_W + CNT_W;
    localparam int BIT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(N - 1);
    localparam logic [CNT_W:0]   c_div  = (CNT_W + 1)'(N);
    localparam logic [BIT_W-1:0] c_top  = BIT_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mode;
    logic [CNT_W-1:0]  r_part;
    logic [DATA_W-1:0] r_quo;
    logic [BIT_W-1:0]  r_bit;
    logic [ACC_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_mean;
    logic [CNT_W-1:0]  r_rem;
    logic              r_zoz;

    logic              w_accept;
    logic              w_last;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [CNT_W:0]    w_trial;
    logic              w_qbit;
    logic [CNT_W-1:0]  w_part_nxt;
    logic [DATA_W-1:0] w_quo_nxt;

    assign w_accept  = (r_state == ACCUM) && bus.in_valid && !bus.clear;
    assign w_last    = (r_cnt == c_last);
    assign w_acc_nxt = r_acc + {{CNT_W{1'b0}}, bus.in_data};

    // One restoring-division step per cycle, dividend bits taken MSB first.
    // The quotient is known to fit DATA_W, so its upper bits are simply dropped.
    assign w_trial    = {r_part, r_acc[r_bit]};
    assign w_qbit     = (w_trial >= c_div);
    assign w_part_nxt = w_qbit ? CNT_W'(w_trial - c_div) : CNT_W'(w_trial);
    assign w_quo_nxt  = DATA_W'({r_quo, w_qbit});

    assign bus.in_ready = (r_state == ACCUM);
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.sum      = r_sum;
    assign bus.mean     = r_mean;
    assign bus.rem      = r_rem;
    assign bus.zOz      = r_zoz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.start) w_state_nxt = ACCUM;
                ACCUM:   if (w_accept && w_last) w_state_nxt = r_mode ? DONE : DIVIDE;
                DIVIDE:  if (r_bit == '0) w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_part <= '0;
            r_quo  <= '0;
            r_bit  <= '0;
            r_sum  <= '0;
            r_mean <= '0;
            r_rem  <= '0;
            r_zoz  <= 1'b0;
        end else if (bus.clear) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_part <= '0;
            r_quo  <= '0;
            r_bit  <= '0;
            r_sum  <= '0;
            r_mean <= '0;
            r_rem  <= '0;
            r_zoz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_mode <= bus.mode;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            if (r_mode) begin
                                r_sum  <= w_acc_nxt;
                                r_mean <= '0;
                                r_rem  <= '0;
                                r_zoz  <= (w_acc_nxt == '0);
                            end else begin
                                r_part <= '0;
                                r_quo  <= '0;
                                r_bit  <= c_top;
                            end
                        end
                    end
                end
                DIVIDE: begin
                    r_part <= w_part_nxt;
                    r_quo  <= w_quo_nxt;
                    r_bit  <= r_bit - BIT_W'(1);
                    if (r_bit == '0) begin
                        r_sum  <= r_acc;
                        r_mean <= w_quo_nxt;
                        r_rem  <= w_part_nxt;
                        r_zoz  <= (r_acc == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/mean_engine.md
MEAN_ENGINE -- requirements
Module: mean_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-002 The block SHALL have parameter N, default 8, samples per average; legal range 2..255.
REQ-003 The block SHALL have derived parameter CNT_W, equal to $clog2(N+1), sample-counter width.
REQ-004 The block SHALL have derived parameter ACC_W, equal to DATA_W+CNT_W, accumulator width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  begin a new averaging run.
REQ-008 clear  input  1  synchronous abort/flush.
REQ-009 mode  input  1  0 = mean (sum and divide), 1 = sum only.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_data  input  DATA_W  unsigned sample.
REQ-012 in_ready  output  1  block accepts a sample this cycle.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle result-valid pulse.
REQ-015 sum  output  ACC_W  registered sum of the N samples.
REQ-016 mean  output  DATA_W  registered floor(sum/N).
REQ-017 rem  output  CNT_W  registered sum mod N.
REQ-018 zOz  output  1  registered flag, high when the completed sum is 0.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM, DIVIDE and DONE, and SHALL be in IDLE after reset.
REQ-020 In IDLE, start=1 SHALL move the FSM to ACCUM, zero the accumulator and sample counter, and latch mode; in other states start SHALL be ignored.
REQ-021 in_ready SHALL be 1 only in ACCUM; in_valid SHALL be ignored whenever in_ready=0.
REQ-022 A sample SHALL be accepted on an edge where in_valid=1 and in_ready=1; the accumulator SHALL add in_data zero-extended to ACC_W, and the counter SHALL increment.
REQ-023 ACC_W is sized so the accumulator cannot overflow for N samples at full scale; no saturation logic SHALL exist.
REQ-024 On the edge accepting sample N, the FSM SHALL go to DIVIDE when the latched mode is 0, or to DONE when the latched mode is 1; further samples SHALL NOT be accepted.
REQ-025 DIVIDE SHALL perform restoring division of the accumulator by N, producing one quotient bit per cycle over exactly ACC_W cycles, then move to DONE.
REQ-026 On entry to DONE, sum, mean, rem and zOz SHALL be updated.
REQ-027 When the latched mode is 1, mean and rem SHALL be loaded as 0.
REQ-028 The quotient SHALL always fit DATA_W; it SHALL be truncated (floor), not rounded.
REQ-029 done SHALL be high for exactly the one cycle spent in DONE; the FSM SHALL then return to IDLE.
REQ-030 Latency, mode 1: done SHALL be high in the cycle immediately after the sample-N accept edge.
REQ-031 Latency, mode 0: done SHALL be high ACC_W cycles after the mode-1 timing.
REQ-032 Result outputs SHALL hold their values until the next DONE, a clear or a reset.
REQ-033 clear=1 SHALL, on the next edge from any state, force IDLE, zero the accumulator, counter, sum, mean, rem and zOz, and suppress done.
REQ-034 clear SHALL have priority over start and over sample acceptance in the same cycle.
REQ-035 start=1 together with clear=1 in IDLE SHALL leave the FSM in IDLE.
REQ-036 Gaps in in_valid SHALL only stretch ACCUM; the result SHALL be independent of gap timing.

Reset
REQ-037 Asserting rst SHALL immediately, without waiting for clk, force IDLE and drive in_ready, busy, done, sum, mean, rem and zOz to 0; this applies in every state, including mid-DIVIDE.
REQ-038 After rst deasserts, the first operation SHALL require a fresh start.

Verification (defaults: DATA_W=8, N=8, ACC_W=12)
REQ-039 Bench SHALL cover mode 0 with samples 1..8 back-to-back -> sum=36, mean=4, rem=4, zOz=0, done a single pulse 12 cycles after the mode-1 timing.
REQ-040 Bench SHALL cover mode 1 with eight samples of 255 -> sum=2040, mean=0, rem=0, done in the cycle after the 8th accept.
REQ-041 Bench SHALL cover mode 0 with eight zero samples -> sum=0, mean=0, zOz=1.
REQ-042 Bench SHALL cover samples 1..8 with random in_valid gaps, plus in_valid pulses while in IDLE/DIVIDE -> identical result to REQ-039, with the extra pulses ignored.
REQ-043 Bench SHALL cover rst asserted in the 5th DIVIDE cycle -> all outputs 0 with no clock edge; a subsequent full run gives the REQ-039 result.
REQ-044 Bench SHALL cover clear after 3 samples, and start pulses while busy -> IDLE, outputs 0, no done, extra starts ignored; a fresh run gives a correct result.
